conv_mac_engine: RTL and testbench
==================================

CONV_MAC_ENGINE -- requirements
Module: conv_mac_engine

Interface
REQ-001 Parameter DW, default 8: unsigned width of image pixels, kernel taps and result pixels.
REQ-002 Parameter IMG, default 4: square input image side; IMG >= KER.
REQ-003 Parameter KER, default 3: square kernel side; KER >= 1.
REQ-004 Parameter ACCW, default 20: accumulator width; ACCW >= 2*DW + ceil(log2(KER*KER)).
REQ-005 Derived constant OUT = IMG-KER+1: result side. Result count is OUT*OUT.
REQ-006 clk  in  1  clock; all state changes on the rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  single-cycle request; accepted only in IDLE.
REQ-009 flip  in  1  1 = true convolution (kernel rotated 180 degrees), 0 = correlation; sampled at accept.
REQ-010 shift  in  4  right-shift applied to each accumulator before saturation; sampled at accept.
REQ-011 img  in  IMG*IMG*DW  row-major pixels; pixel (r,c) at bits [(r*IMG+c)*DW +: DW]; sampled at accept.
REQ-012 ker  in  KER*KER*DW  row-major taps, same packing; sampled at accept.
REQ-013 busy  out  1  high from the cycle after accept until done is asserted.
REQ-014 out_valid  out  1  one-cycle strobe per finished result pixel.
REQ-015 out_idx  out  ceil(log2(OUT*OUT))  row-major index of the strobed pixel.
REQ-016 out_pix  out  DW  strobed result pixel.
REQ-017 result  out  OUT*OUT*DW  all result pixels, row-major; each field updates on its out_valid cycle.
REQ-018 done  out  1  one-cycle pulse after the last result is written.

Function
REQ-019 FSM states: IDLE, MAC, WRITE, FIN.
REQ-020 IDLE: start=1 captures img, ker, flip and shift into internal registers, clears the accumulator and tap/output counters, and moves to MAC.
REQ-021 MAC: each cycle adds one product to the accumulator; the tap counter (kr,kc) runs row-major over 0..KER-1.
REQ-022 Pixel in MAC: img(orow+kr, ocol+kc). Tap: ker(kr,kc) when flip=0; ker(KER-1-kr, KER-1-kc) when flip=1.
REQ-023 After KER*KER MAC cycles the FSM moves to WRITE.
REQ-024 WRITE lasts one cycle. out_pix = min(acc >> shift, 2^DW-1); out_valid=1; result field out_idx updates; accumulator clears.
REQ-025 From WRITE: if out_idx < OUT*OUT-1, go to MAC and advance (orow,ocol) row-major; otherwise go to FIN.
REQ-026 FIN lasts one cycle: done=1, busy=0, then IDLE.
REQ-027 Latency: done is asserted exactly OUT*OUT*(KER*KER+1)+1 cycles after the accept edge (41 for the defaults).
REQ-028 start while busy or in FIN is ignored; it is not queued.
REQ-029 Input changes after accept do not affect the running job.
REQ-030 result holds its values after done until the next WRITE overwrites them. A new job does not clear result.
REQ-031 All arithmetic is unsigned. Products are 2*DW bits and are zero-extended to ACCW. The accumulator never overflows under REQ-004.

Reset
REQ-032 rst forces IDLE immediately, even mid-job. busy, out_valid, done, out_idx, out_pix, result, the accumulator and all counters reset to 0.
REQ-033 No done is produced for an aborted job.
REQ-034 start is honoured on the first rising edge after rst deasserts.

Structure
REQ-035 Package conv_pkg holds the FSM state enum, the OUT derivation and the index-width functions. It is shared with the future multi-PE array.
REQ-036 The multiply-accumulate datapath is one sub-module, mac_unit (clear, enable, a, b, acc). The FSM and addressing stay in conv_mac_engine.

Verification
REQ-037 Defaults, img all 1, ker all 1, flip=0, shift=0 -> four out_valid strobes with out_pix=9, idx 0..3; done 41 cycles after accept.
REQ-038 img(r,c)=4r+c+1, ker only tap(0,0)=1. flip=0 -> result {1,2,5,6}; flip=1 -> result {11,12,15,16}.
REQ-039 img all 255, ker all 255, shift=0 -> every out_pix=255 (saturated; acc=585225). shift=12 -> 142.
REQ-040 start pulsed at accept+5 and accept+20 -> ignored; exactly one done; busy stays continuous.
REQ-041 rst asserted in the cycle after the second out_valid -> all outputs 0 next cycle; no done; a new start then completes normally in 41 cycles.
REQ-042 Param set IMG=5, KER=2 -> 16 strobes, done 81 cycles after accept; results match a reference model.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and size helpers for the convolution engines (single MAC now, PE array later).
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_t;

    function automatic int out_side(input int img_side, input int ker_side);
        return img_side - ker_side + 1;
    endfunction

    // Width of a counter/index that must address n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_mac_engine_mac.sv
// Unsigned multiply-accumulate slice: one product per enabled cycle, synchronous clear.
module mac_unit #(
    parameter int DW   = 8,
    parameter int ACCW = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            enable,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [ACCW-1:0] acc
);
    logic [2*DW-1:0] prod;
    logic [ACCW-1:0] acc_q;

    assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    assign acc  = acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (enable) begin
            acc_q <= acc_q + ACCW'(prod);
        end
    end

endmodule

// File: rtl/conv_mac_engine.sv
// Sequential 2-D convolution/correlation: one MAC per cycle, one result pixel per KER*KER+1 cycles.
module conv_mac_engine
    import conv_pkg::*;
#(
    parameter int DW   = 8,
    parameter int IMG  = 4,
    parameter int KER  = 3,
    parameter int ACCW = 20,
    localparam int OUT  = out_side(IMG, KER),
    localparam int IDXW = idx_w(OUT * OUT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  flip,
    input  logic [3:0]            shift,
    input  logic [IMG*IMG*DW-1:0] img,
    input  logic [KER*KER*DW-1:0] ker,
    output logic                  busy,
    output logic                  out_valid,
    output logic [IDXW-1:0]       out_idx,
    output logic [DW-1:0]         out_pix,
    output logic [OUT*OUT*DW-1:0] result,
    output logic                  done
);
    localparam int KW  = idx_w(KER);
    localparam int OW  = idx_w(OUT);
    localparam int PAW = idx_w(IMG * IMG);
    localparam int TAW = idx_w(KER * KER);
    localparam logic [ACCW-1:0] PIX_MAX = ACCW'({DW{1'b1}});

    state_t                state_q, state_d;
    logic [IMG*IMG*DW-1:0] img_q;
    logic [KER*KER*DW-1:0] ker_q;
    logic                  flip_q;
    logic [3:0]            shift_q;
    logic [KW-1:0]         kr_q, kc_q;
    logic [OW-1:0]         orow_q, ocol_q;
    logic [IDXW-1:0]       idx_q;
    logic                  busy_q, out_valid_q, done_q;
    logic [IDXW-1:0]       out_idx_q;
    logic [DW-1:0]         out_pix_q;
    logic [OUT*OUT*DW-1:0] result_q;

    logic                  accept, mac_clear, mac_en, last_tap, last_pix;
    logic [DW-1:0]         img_px [IMG*IMG];
    logic [DW-1:0]         ker_px [KER*KER];
    logic [PAW-1:0]        pix_addr;
    logic [TAW-1:0]        tap_addr;
    logic [DW-1:0]         mac_a, mac_b;
    logic [ACCW-1:0]       acc, acc_shr;
    logic [DW-1:0]         sat_pix;

    genvar gi;
    for (gi = 0; gi < IMG * IMG; gi++) begin : g_img
        assign img_px[gi] = img_q[gi*DW +: DW];
    end
    for (gi = 0; gi < KER * KER; gi++) begin : g_ker
        assign ker_px[gi] = ker_q[gi*DW +: DW];
    end

    // Flip reads the kernel back to front, i.e. rotated by 180 degrees.
    always_comb begin
        pix_addr = PAW'((int'(orow_q) + int'(kr_q)) * IMG + int'(ocol_q) + int'(kc_q));
        if (flip_q) begin
            tap_addr = TAW'((KER - 1 - int'(kr_q)) * KER + (KER - 1 - int'(kc_q)));
        end else begin
            tap_addr = TAW'(int'(kr_q) * KER + int'(kc_q));
        end
    end

    assign mac_a   = img_px[pix_addr];
    assign mac_b   = ker_px[tap_addr];
    assign acc_shr = acc >> shift_q;
    assign sat_pix = (acc_shr > PIX_MAX) ? {DW{1'b1}} : acc_shr[DW-1:0];

    assign last_tap = (kr_q == KW'(KER - 1)) && (kc_q == KW'(KER - 1));
    assign last_pix = (idx_q == IDXW'(OUT * OUT - 1));

    mac_unit #(.DW(DW), .ACCW(ACCW)) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clear  (mac_clear),
        .enable (mac_en),
        .a      (mac_a),
        .b      (mac_b),
        .acc    (acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        mac_clear = 1'b0;
        mac_en    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                accept    = 1'b1;
                mac_clear = 1'b1;
                state_d   = MAC;
            end
            MAC: begin
                mac_en = 1'b1;
                if (last_tap) state_d = WRITE;
            end
            WRITE: begin
                mac_clear = 1'b1;
                state_d   = last_pix ? FIN : MAC;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered on the edge that completes each state's action.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            img_q       <= '0;
            ker_q       <= '0;
            flip_q      <= 1'b0;
            shift_q     <= '0;
            kr_q        <= '0;
            kc_q        <= '0;
            orow_q      <= '0;
            ocol_q      <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            out_idx_q   <= '0;
            out_pix_q   <= '0;
            result_q    <= '0;
        end else begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            if (accept) begin
                img_q   <= img;
                ker_q   <= ker;
                flip_q  <= flip;
                shift_q <= shift;
                kr_q    <= '0;
                kc_q    <= '0;
                orow_q  <= '0;
                ocol_q  <= '0;
                idx_q   <= '0;
                busy_q  <= 1'b1;
            end
            case (state_q)
                MAC: begin
                    if (kc_q == KW'(KER - 1)) begin
                        kc_q <= '0;
                        kr_q <= (kr_q == KW'(KER - 1)) ? '0 : kr_q + KW'(1);
                    end else begin
                        kc_q <= kc_q + KW'(1);
                    end
                end
                WRITE: begin
                    out_valid_q                  <= 1'b1;
                    out_idx_q                    <= idx_q;
                    out_pix_q                    <= sat_pix;
                    result_q[int'(idx_q)*DW +: DW] <= sat_pix;
                    idx_q                        <= idx_q + IDXW'(1);
                    if (ocol_q == OW'(OUT - 1)) begin
                        ocol_q <= '0;
                        orow_q <= (orow_q == OW'(OUT - 1)) ? '0 : orow_q + OW'(1);
                    end else begin
                        ocol_q <= ocol_q + OW'(1);
                    end
                end
                FIN: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_pix   = out_pix_q;
    assign result    = result_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed bench: default 4x4/3x3 engine plus a 5x5/2x2 instance checked against a small reference.
module tb_conv_mac_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, flip;
    logic [3:0]   shift;
    logic [127:0] img;
    logic [71:0]  ker;
    logic         busy, out_valid, done;
    logic [1:0]   out_idx;
    logic [7:0]   out_pix;
    logic [31:0]  result;

    logic         start2, flip2;
    logic [3:0]   shift2;
    logic [199:0] img2;
    logic [31:0]  ker2;
    logic         busy2, out_valid2, done2;
    logic [3:0]   out_idx2;
    logic [7:0]   out_pix2;
    logic [127:0] result2;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0] got_pix [16];
    int         got_cnt, got_lat;
    bit         idx_ok, busy_ok;

    conv_mac_engine #(.DW(8), .IMG(4), .KER(3), .ACCW(20)) dut (
        .clk(clk), .rst(rst), .start(start), .flip(flip), .shift(shift),
        .img(img), .ker(ker), .busy(busy), .out_valid(out_valid),
        .out_idx(out_idx), .out_pix(out_pix), .result(result), .done(done)
    );

    conv_mac_engine #(.DW(8), .IMG(5), .KER(2), .ACCW(20)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .flip(flip2), .shift(shift2),
        .img(img2), .ker(ker2), .busy(busy2), .out_valid(out_valid2),
        .out_idx(out_idx2), .out_pix(out_pix2), .result(result2), .done(done2)
    );

    // Runs one job on the default instance; inputs are scrambled right after accept.
    task automatic run_job(input logic [127:0] im, input logic [71:0] kv, input logic f,
                           input logic [3:0] sh, input bit pulse);
        img = im; ker = kv; flip = f; shift = sh; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; img = ~im; ker = ~kv; flip = ~f; shift = ~sh;
        got_cnt = 0; got_lat = 0; idx_ok = 1'b1; busy_ok = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            start = pulse && (c == 5 || c == 20 || c == 41);
            @(posedge clk); #1;
            if (out_valid) begin
                if (got_cnt >= 4 || out_idx != 2'(got_cnt)) idx_ok = 1'b0;
                else got_pix[got_cnt] = out_pix;
                got_cnt++;
            end
            if (done) begin
                got_lat = c;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        start = 1'b0;
        $display("job: flip=%0d shift=%0d latency=%0d strobes=%0d result=%h",
                 f, sh, got_lat, got_cnt, result);
    endtask

    task automatic check_job(input string name, input int exp_lat, input logic [31:0] exp_res);
        vec_cnt++;
        if (got_lat !== exp_lat) begin
            err_cnt++;
            $display("FAIL %s_latency: got %0d expected %0d", name, got_lat, exp_lat);
        end
        vec_cnt++;
        if (got_cnt !== 4 || !idx_ok) begin
            err_cnt++;
            $display("FAIL %s_strobes: got %0d strobes idx_ok=%0d expected 4 in order", name, got_cnt, idx_ok);
        end
        vec_cnt++;
        if (!busy_ok) begin
            err_cnt++;
            $display("FAIL %s_busy: busy dropped before done, expected continuous", name);
        end
        vec_cnt++;
        if (result !== exp_res) begin
            err_cnt++;
            $display("FAIL %s_result: got %h expected %h", name, result, exp_res);
        end
        for (int i = 0; i < 4; i++) begin
            vec_cnt++;
            if (got_pix[i] !== exp_res[i*8 +: 8]) begin
                err_cnt++;
                $display("FAIL %s_pix%0d: got %0d expected %0d", name, i, got_pix[i], exp_res[i*8 +: 8]);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; flip = 1'b0; shift = '0; img = '0; ker = '0;
        start2 = 1'b0; flip2 = 1'b0; shift2 = '0; img2 = '0; ker2 = '0;
        repeat (3) @(posedge clk);
        #1;
        vec_cnt++;
        if ({busy, out_valid, done} !== 3'b000) begin
            err_cnt++;
            $display("FAIL reset_ctrl: busy/valid/done=%b expected 000", {busy, out_valid, done});
        end
        vec_cnt++;
        if (out_idx !== 2'd0 || out_pix !== 8'd0 || result !== 32'd0) begin
            err_cnt++;
            $display("FAIL reset_data: idx=%0d pix=%0d result=%h expected all 0", out_idx, out_pix, result);
        end
        rst = 1'b0;
    endtask

    task automatic test_all_ones;
        logic [127:0] im;
        logic [71:0]  kv;
        for (int i = 0; i < 16; i++) im[i*8 +: 8] = 8'd1;
        for (int i = 0; i < 9; i++)  kv[i*8 +: 8] = 8'd1;
        run_job(im, kv, 1'b0, 4'd0, 1'b0);
        check_job("all_ones", 41, 32'h09090909);
    endtask

    task automatic test_flip;
        logic [127:0] im;
        logic [71:0]  kv;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) im[(r*4+c)*8 +: 8] = 8'(4*r + c + 1);
        kv = 72'd1;
        run_job(im, kv, 1'b0, 4'd0, 1'b0);
        check_job("corr", 41, 32'h06050201);
        repeat (5) @(posedge clk);
        #1;
        vec_cnt++;
        if (result !== 32'h06050201) begin
            err_cnt++;
            $display("FAIL result_hold: got %h expected %h", result, 32'h06050201);
        end
        run_job(im, kv, 1'b1, 4'd0, 1'b0);
        check_job("conv", 41, 32'h100F0C0B);
    endtask

    task automatic test_saturate;
        logic [127:0] im;
        logic [71:0]  kv;
        im = '1;
        kv = '1;
        run_job(im, kv, 1'b0, 4'd0, 1'b0);
        check_job("sat_sh0", 41, 32'hFFFFFFFF);
        run_job(im, kv, 1'b0, 4'd11, 1'b0);
        check_job("sat_sh11", 41, 32'hFFFFFFFF);
        run_job(im, kv, 1'b0, 4'd12, 1'b0);
        check_job("sat_sh12", 41, 32'h8E8E8E8E);
    endtask

    task automatic test_start_ignored;
        logic [127:0] im;
        logic [71:0]  kv;
        int extra_done, extra_busy;
        for (int i = 0; i < 16; i++) im[i*8 +: 8] = 8'd2;
        for (int i = 0; i < 9; i++)  kv[i*8 +: 8] = 8'd1;
        run_job(im, kv, 1'b0, 4'd0, 1'b1);
        check_job("start_ign", 41, 32'h12121212);
        extra_done = 0; extra_busy = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        vec_cnt++;
        if (extra_done != 0 || extra_busy != 0) begin
            err_cnt++;
            $display("FAIL start_queued: extra done=%0d busy cycles=%0d expected 0/0", extra_done, extra_busy);
        end
    endtask

    task automatic test_reset_abort;
        logic [127:0] im;
        logic [71:0]  kv;
        int n, stray;
        for (int i = 0; i < 16; i++) im[i*8 +: 8] = 8'd1;
        for (int i = 0; i < 9; i++)  kv[i*8 +: 8] = 8'd1;
        img = im; ker = kv; flip = 1'b0; shift = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 100 && n < 2; c++) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        vec_cnt++;
        if ({busy, out_valid, done} !== 3'b000 || out_idx !== 2'd0 || out_pix !== 8'd0 || result !== 32'd0) begin
            err_cnt++;
            $display("FAIL abort_clear: bvd=%b idx=%0d pix=%0d result=%h expected all 0",
                     {busy, out_valid, done}, out_idx, out_pix, result);
        end
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (done || busy || out_valid) stray++;
        end
        vec_cnt++;
        if (stray != 0) begin
            err_cnt++;
            $display("FAIL abort_done: %0d stray active cycles expected 0", stray);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        run_job(im, kv, 1'b0, 4'd0, 1'b0);
        check_job("after_rst", 41, 32'h09090909);
    endtask

    task automatic test_param_set;
        logic [7:0] exp_pix [16];
        logic [127:0] exp_res;
        int acc, tap, cnt, lat;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) img2[(r*5+c)*8 +: 8] = 8'(r*5 + c + 1);
        ker2 = {8'd4, 8'd3, 8'd2, 8'd1};
        for (int o = 0; o < 16; o++) begin
            acc = 0;
            for (int kr = 0; kr < 2; kr++)
                for (int kc = 0; kc < 2; kc++) begin
                    tap = (1 - kr) * 2 + (1 - kc);
                    acc += ((o/4 + kr) * 5 + (o%4 + kc) + 1) * (tap + 1);
                end
            acc = acc >> 1;
            exp_pix[o] = (acc > 255) ? 8'd255 : 8'(acc);
            exp_res[o*8 +: 8] = exp_pix[o];
        end
        flip2 = 1'b1; shift2 = 4'd1; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0; img2 = ~img2; ker2 = ~ker2; flip2 = 1'b0; shift2 = 4'd0;
        cnt = 0; lat = 0;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            if (out_valid2) begin
                if (cnt < 16) begin
                    vec_cnt++;
                    if (out_idx2 !== 4'(cnt) || out_pix2 !== exp_pix[cnt]) begin
                        err_cnt++;
                        $display("FAIL p2_pix%0d: got idx %0d pix %0d expected idx %0d pix %0d",
                                 cnt, out_idx2, out_pix2, cnt, exp_pix[cnt]);
                    end
                end
                cnt++;
            end
            if (done2) begin
                lat = c;
                break;
            end
        end
        $display("job p2: latency=%0d strobes=%0d result=%h", lat, cnt, result2);
        vec_cnt++;
        if (lat !== 81 || cnt !== 16) begin
            err_cnt++;
            $display("FAIL p2_latency: got latency %0d strobes %0d expected 81/16", lat, cnt);
        end
        vec_cnt++;
        if (result2 !== exp_res) begin
            err_cnt++;
            $display("FAIL p2_result: got %h expected %h", result2, exp_res);
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_flip();
        test_saturate();
        test_start_ignored();
        test_reset_abort();
        test_param_set();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
